// File: rtl/wfg_mem_pkg.sv
// Shared types and constants for the waveform-generator sample-memory bank.
// Provides the default word-address width, the byte-lane geometry of the
// four 512x8 macros, the read-owner enum and a byte-mask expansion helper.
package wfg_mem_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 9;
    localparam int unsigned DATA_WIDTH         = 32;
    localparam int unsigned NUM_LANES          = 4;
    localparam int unsigned LANE_WIDTH         = 8;

    // Which port (if any) owns the data the macros present this cycle.
    // Also reused as the per-cycle grant encoding.
    typedef enum logic [1:0] {
        RD_OWN_NONE = 2'd0,
        RD_OWN_P0   = 2'd1,
        RD_OWN_P1   = 2'd2
    } rd_own_e;

    // Expand a byte write mask (1 = write) into active-low per-bit enables.
    function automatic logic [DATA_WIDTH-1:0] lane_wen_n(input logic [NUM_LANES-1:0] mask);
        logic [DATA_WIDTH-1:0] wen;
        wen = '1;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            wen[k*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{~mask[k]}};
        end
        return wen;
    endfunction

endpackage

// File: rtl/sram_read_hold.sv
// Read-data return path for one port.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   match_i   this port owns the macro output this cycle
//   sram_q_i  macro read data
//   dout_o    live macro data when owned, otherwise the last data returned
module sram_read_hold
    import wfg_mem_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  match_i,
    input  logic [DATA_WIDTH-1:0] sram_q_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] hold_d;

    // Capture at the end of every cycle this port owns the read data.
    always_comb begin
        hold_d = hold_q;
        if (match_i) begin
            hold_d = sram_q_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // A return in flight when reset hits is dropped, not shown.
    always_comb begin
        dout_o = hold_q;
        if (rst_i) begin
            dout_o = '0;
        end else if (match_i) begin
            dout_o = sram_q_i;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port to single-port adapter for one bank of four 512x8 SRAM macros.
// Port 1 (streaming read) has fixed priority and never stalls; port 0
// (Wishbone read/write) is stalled on conflict and acked one cycle after
// acceptance.
// Ports:
//   io_wbs_clk, io_wbs_rst         clock, synchronous active-high reset
//   csb0_i/web0_i/wmask0_i/addr0_i/din0_i  port 0 request
//   dout0_o/stall0_o/ack0_o        port 0 response
//   csb1_i/addr1_i, dout1_o        port 1 read request / data
//   sram_*                         shared macro pins (byte k -> macro k)
//   stall_cnt_o                    saturating port-0 stall cycle count
module sram_port_arbiter
    import wfg_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int unsigned STALL_CNT_WIDTH = 8
) (
    input  logic                       io_wbs_clk,
    input  logic                       io_wbs_rst,
    input  logic                       csb0_i,
    input  logic                       web0_i,
    input  logic [NUM_LANES-1:0]       wmask0_i,
    input  logic [ADDR_WIDTH-1:0]      addr0_i,
    input  logic [DATA_WIDTH-1:0]      din0_i,
    output logic [DATA_WIDTH-1:0]      dout0_o,
    output logic                       stall0_o,
    output logic                       ack0_o,
    input  logic                       csb1_i,
    input  logic [ADDR_WIDTH-1:0]      addr1_i,
    output logic [DATA_WIDTH-1:0]      dout1_o,
    output logic                       sram_cen_o,
    output logic                       sram_gwen_o,
    output logic [DATA_WIDTH-1:0]      sram_wen_o,
    output logic [ADDR_WIDTH-1:0]      sram_a_o,
    output logic [DATA_WIDTH-1:0]      sram_d_o,
    input  logic [DATA_WIDTH-1:0]      sram_q_i,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

    rd_own_e                    grant;
    rd_own_e                    rd_own_q;
    rd_own_e                    rd_own_d;
    logic                       ack_q;
    logic                       ack_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_d;

    // Per-cycle grant: reset blocks everything, port 1 beats port 0.
    always_comb begin
        grant = RD_OWN_NONE;
        if (!io_wbs_rst) begin
            if (!csb1_i) begin
                grant = RD_OWN_P1;
            end else if (!csb0_i) begin
                grant = RD_OWN_P0;
            end
        end
    end

    assign stall0_o = ~csb0_i & ~csb1_i & ~io_wbs_rst;

    // Macro pin mux from the granted port.
    always_comb begin
        sram_cen_o  = 1'b1;
        sram_gwen_o = 1'b1;
        sram_wen_o  = '1;
        sram_a_o    = addr0_i;
        sram_d_o    = din0_i;
        case (grant)
            RD_OWN_P1: begin
                sram_cen_o = 1'b0;
                sram_a_o   = addr1_i;
            end
            RD_OWN_P0: begin
                sram_cen_o = 1'b0;
                if (!web0_i) begin
                    sram_gwen_o = 1'b0;
                    sram_wen_o  = lane_wen_n(wmask0_i);
                end
            end
            default: ;
        endcase
    end

    // Next state: read owner, ack, saturating stall counter.
    always_comb begin
        rd_own_d    = RD_OWN_NONE;
        ack_d       = 1'b0;
        stall_cnt_d = stall_cnt_q;
        if (grant == RD_OWN_P1) begin
            rd_own_d = RD_OWN_P1;
        end else if (grant == RD_OWN_P0) begin
            ack_d = 1'b1;
            // Writes return no data, so they must not take over the output.
            if (web0_i) begin
                rd_own_d = RD_OWN_P0;
            end
        end
        if (stall0_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            rd_own_q    <= RD_OWN_NONE;
            ack_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            rd_own_q    <= rd_own_d;
            ack_q       <= ack_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A pending ack is dropped if reset arrives in its cycle.
    assign ack0_o      = ack_q & ~io_wbs_rst;
    assign stall_cnt_o = stall_cnt_q;

    sram_read_hold u_hold0 (
        .clk_i    (io_wbs_clk),
        .rst_i    (io_wbs_rst),
        .match_i  (rd_own_q == RD_OWN_P0),
        .sram_q_i (sram_q_i),
        .dout_o   (dout0_o)
    );

    sram_read_hold u_hold1 (
        .clk_i    (io_wbs_clk),
        .rst_i    (io_wbs_rst),
        .match_i  (rd_own_q == RD_OWN_P1),
        .sram_q_i (sram_q_i),
        .dout_o   (dout1_o)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 512x32 macro bank.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [8:0]  addr0, addr1;
    logic [31:0] din0, dout0, dout1;
    logic        stall0, ack0;
    logic        cen, gwen;
    logic [31:0] wen, sd, sq;
    logic [8:0]  sa;
    logic [7:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [512];

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .io_wbs_clk  (clk),
        .io_wbs_rst  (rst),
        .csb0_i      (csb0),
        .web0_i      (web0),
        .wmask0_i    (wmask0),
        .addr0_i     (addr0),
        .din0_i      (din0),
        .dout0_o     (dout0),
        .stall0_o    (stall0),
        .ack0_o      (ack0),
        .csb1_i      (csb1),
        .addr1_i     (addr1),
        .dout1_o     (dout1),
        .sram_cen_o  (cen),
        .sram_gwen_o (gwen),
        .sram_wen_o  (wen),
        .sram_a_o    (sa),
        .sram_d_o    (sd),
        .sram_q_i    (sq),
        .stall_cnt_o (stall_cnt)
    );

    // Macro bank: per-bit active-low write, registered read output.
    always @(posedge clk) begin
        if (!cen) begin
            if (!gwen) begin
                mem[sa] <= (mem[sa] & wen) | (sd & ~wen);
            end else begin
                sq <= mem[sa];
            end
        end
    end

    function automatic logic [31:0] pat(input int j);
        return 32'h5A000000 + 32'(j) * 32'h00010001;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
        wmask0 = 4'hF; addr0 = '0; addr1 = '0; din0 = '0;
        step();
        // Requests during reset: no stall, no macro access.
        csb0 = 1'b0; csb1 = 1'b0;
        #1;
        check("rst_stall0", 32'(stall0), 32'h0);
        check("rst_cen", 32'(cen), 32'h1);
        check("rst_gwen", 32'(gwen), 32'h1);
        csb0 = 1'b1; csb1 = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("idle_cen", 32'(cen), 32'h1);
        check("idle_wen", wen, 32'hFFFFFFFF);
        check("idle_ack", 32'(ack0), 32'h0);
        check("idle_cnt", 32'(stall_cnt), 32'h0);
        check("idle_dout0", dout0, 32'h0);
        check("idle_dout1", dout1, 32'h0);

        // Port 0 full write then read-back.
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'h005; din0 = 32'hDEADBEEF;
        #1;
        check("wr_cen", 32'(cen), 32'h0);
        check("wr_gwen", 32'(gwen), 32'h0);
        check("wr_wen", wen, 32'h0);
        check("wr_a", 32'(sa), 32'h5);
        step();
        web0 = 1'b1;
        #1;
        check("wr_ack", 32'(ack0), 32'h1);
        check("rd_gwen", 32'(gwen), 32'h1);
        step();
        csb0 = 1'b1;
        #1;
        check("rd_ack", 32'(ack0), 32'h1);
        check("rd_dout0", dout0, 32'hDEADBEEF);
        step();
        check("rd_ack_done", 32'(ack0), 32'h0);
        check("rd_dout0_hold", dout0, 32'hDEADBEEF);

        // Partial write (lanes 0 and 2), then port-1 read of the same word.
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0101; din0 = 32'h11223344;
        #1;
        check("pw_wen", wen, 32'hFF00FF00);
        step();
        csb0 = 1'b1; csb1 = 1'b0; addr1 = 9'h005;
        #1;
        check("pw_ack", 32'(ack0), 32'h1);
        check("p1_cen", 32'(cen), 32'h0);
        step();
        csb1 = 1'b1;
        #1;
        check("p1_dout1", dout1, 32'hDE22BE44);
        check("p1_dout0_kept", dout0, 32'hDEADBEEF);

        // Empty-mask write: accepted, acked, memory unchanged.
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0000; din0 = 32'h0;
        #1;
        check("mw0_gwen", 32'(gwen), 32'h0);
        check("mw0_wen", wen, 32'hFFFFFFFF);
        step();
        csb0 = 1'b1; csb1 = 1'b0;
        #1;
        check("mw0_ack", 32'(ack0), 32'h1);
        step();
        csb1 = 1'b1;
        #1;
        check("mw0_dout1", dout1, 32'hDE22BE44);
        step();

        // Contention for 3 cycles, then port 1 releases.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 9'h005; csb1 = 1'b0; addr1 = 9'h005;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("ct_stall", 32'(stall0), 32'h1);
            check("ct_noack", 32'(ack0), 32'h0);
            check("ct_a", 32'(sa), 32'h5);
            step();
        end
        csb1 = 1'b1;
        #1;
        check("ct_grant_stall", 32'(stall0), 32'h0);
        check("ct_grant_cen", 32'(cen), 32'h0);
        check("ct_grant_noack", 32'(ack0), 32'h0);
        step();
        csb0 = 1'b1;
        #1;
        check("ct_ack", 32'(ack0), 32'h1);
        check("ct_dout0", dout0, 32'hDE22BE44);
        check("ct_cnt", 32'(stall_cnt), 32'h3);
        step();

        // Fill 100..399 through port 0 with a known pattern.
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF;
        for (int j = 100; j < 400; j++) begin
            addr0 = 9'(j); din0 = pat(j);
            step();
        end
        csb0 = 1'b1; web0 = 1'b1;
        step();

        // 300 back-to-back port-1 reads against a waiting port 0.
        csb0 = 1'b0; addr0 = 9'h005;
        for (int i = 0; i < 300; i++) begin
            csb1 = 1'b0; addr1 = 9'(100 + i);
            #1;
            check("sat_stall", 32'(stall0), 32'h1);
            if (i > 0) begin
                check("sat_dout1", dout1, pat(99 + i));
            end
            step();
        end
        csb1 = 1'b1;
        #1;
        check("sat_dout1_last", dout1, pat(399));
        check("sat_cnt", 32'(stall_cnt), 32'hFF);
        step();
        csb0 = 1'b1;
        #1;
        check("sat_ack", 32'(ack0), 32'h1);
        check("sat_dout0", dout0, 32'hDE22BE44);
        check("sat_dout1_hold", dout1, pat(399));
        check("sat_cnt_held", 32'(stall_cnt), 32'hFF);
        step();

        // Reset in the cycle after a port-0 read is accepted.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 9'h005;
        step();
        rst = 1'b1; csb0 = 1'b1;
        #1;
        check("mr_noack", 32'(ack0), 32'h0);
        check("mr_dout0", dout0, 32'h0);
        check("mr_cen", 32'(cen), 32'h1);
        step();
        rst = 1'b0;
        #1;
        check("mr_after_ack", 32'(ack0), 32'h0);
        check("mr_after_dout0", dout0, 32'h0);
        check("mr_after_dout1", dout1, 32'h0);
        check("mr_after_cnt", 32'(stall_cnt), 32'h0);
        step();
        check("mr_later_dout0", dout0, 32'h0);
        check("mr_later_ack", 32'(ack0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
